// File: rtl/wordcell_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wordcell_ctrl_pkg
// Purpose  : Shared types and helpers for the Wordcell array controller:
//            the sequencer state encoding, the array operation codes and a
//            constant-foldable ceil(log2) used to size internal counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wordcell_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_SEL    = 3'd4,
    R_DONE   = 3'd5,
    ERR      = 3'd6
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage : wordcell_ctrl_pkg
`default_nettype wire

// File: rtl/wordcell_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wordcell_rr_arbiter
// Purpose  : Two-way round-robin arbiter. On a tie the requester that did not
//            win last time is granted. Purely combinational.
// Ports    : req_valid  [1:0] in  - per-requester valid
//            last_grant       in  - index of the most recent winner
//            enable           in  - grant only while the controller is idle
//            grant      [1:0] out - one-hot or zero grant
// Revision : 1.0 - initial release
// ============================================================================
module wordcell_rr_arbiter (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule : wordcell_rr_arbiter
`default_nettype wire

// File: rtl/wordcell_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wordcell_array_ctrl
// Purpose  : Sequencing controller for an array of 8-bit NAND-latch
//            Wordcells shared by two requesters. Writes are framed by a setup
//            and a hold cycle around a WR_PULSE-cycle latch strobe; reads hold
//            the word select for RD_WAIT cycles and then capture out_bus.
//            Every array-facing signal comes straight from a flop so the latch
//            enables can never glitch.
// Ports    : clk, rst_n               - clock, async active-low reset
//            req_valid/req_ready [1:0] - request handshake per requester
//            req_we, req_addr, req_wdata - per-requester request fields
//            rsp_valid, rsp_id, rsp_err, rsp_rdata - completion response
//            sel_x, op, in_bus        - array controls / write data
//            out_bus                  - array read data
// Revision : 1.0 - initial release
// ============================================================================
module wordcell_array_ctrl
  import wordcell_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WR_PULSE  = 2,
  parameter int RD_WAIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [NUM_WORDS-1:0]  sel_x,
  output logic                  op,
  output logic [DATA_W-1:0]     in_bus,
  input  logic [DATA_W-1:0]     out_bus
);

  // The counter only ever holds (pulse length - 1), so clog2 of the longer
  // phase is enough; keep at least one bit.
  localparam int CNT_MAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  // One extra bit so the full request address is compared, never truncated.
  localparam logic [ADDR_W:0]  WORDS_LIMIT = (ADDR_W + 1)'(NUM_WORDS);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  last_grant;
  logic [NUM_WORDS-1:0]  lat_sel;
  logic                  lat_id;

  logic [1:0]            grant;
  logic                  handshake;
  logic                  gid;
  logic                  g_we;
  logic [ADDR_W-1:0]     g_addr;
  logic [DATA_W-1:0]     g_wdata;
  logic                  g_in_range;
  logic [NUM_WORDS-1:0]  g_sel;

  wordcell_rr_arbiter u_arbiter (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign handshake = |(req_valid & grant);
  assign gid       = grant[1];

  // Fields of the granted requester.
  assign g_we       = gid ? req_we[1] : req_we[0];
  assign g_addr     = gid ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign g_wdata    = gid ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign g_in_range = ({1'b0, g_addr} < WORDS_LIMIT);
  // Only consumed when the address is in range, so the shift never drops the bit.
  assign g_sel      = NUM_WORDS'(1) << g_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      lat_sel    <= '0;
      lat_id     <= 1'b0;
      sel_x      <= '0;
      op         <= OP_READ;
      in_bus     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_bus deliberately keeps its last value here.
          sel_x     <= '0;
          op        <= OP_READ;
          rsp_valid <= 1'b0;
          if (handshake) begin
            last_grant <= gid;
            lat_id     <= gid;
            lat_sel    <= g_sel;
            if (!g_in_range) begin
              state     <= ERR;
              rsp_valid <= 1'b1;
              rsp_id    <= gid;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (g_we) begin
              state  <= W_SETUP;
              in_bus <= g_wdata;
            end else begin
              state <= R_SEL;
              sel_x <= g_sel;
              cnt   <= RD_LOAD;
            end
          end
        end

        // Data has been stable on in_bus for a full cycle before the enable rises.
        W_SETUP: begin
          sel_x <= lat_sel;
          op    <= OP_WRITE;
          cnt   <= WR_LOAD;
          state <= W_STROBE;
        end

        W_STROBE: begin
          if (cnt == '0) begin
            sel_x     <= '0;
            op        <= OP_READ;
            state     <= W_HOLD;
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        R_SEL: begin
          if (cnt == '0) begin
            rsp_rdata <= out_bus;
            sel_x     <= '0;
            state     <= R_DONE;
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // Response cycles: the pulse ends, response fields hold.
        W_HOLD, R_DONE, ERR: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          sel_x     <= '0;
          op        <= OP_READ;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : wordcell_array_ctrl
`default_nettype wire

// File: tb/tb_wordcell_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wordcell_array_ctrl
// Purpose  : Self-checking bench for wordcell_array_ctrl with a behavioural
//            4-word latch array and a transaction-level reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_wordcell_array_ctrl;

  localparam int NW  = 4;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int WRP = 2;
  localparam int RDW = 1;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_id;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [NW-1:0]   sel_x;
  logic            op;
  logic [DW-1:0]   in_bus;
  logic [DW-1:0]   out_bus;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [NW];       // behavioural latch array contents
  logic [DW-1:0] exp_mem [NW];   // reference model of the array
  logic          model_last;     // reference model of the last winner

  wordcell_array_ctrl #(
    .NUM_WORDS (NW), .ADDR_W (AW), .DATA_W (DW), .WR_PULSE (WRP), .RD_WAIT (RDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .sel_x     (sel_x),
    .op        (op),
    .in_bus    (in_bus),
    .out_bus   (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transparent latches: a selected word follows in_bus while op is high.
  always @(op or sel_x or in_bus) begin
    for (int i = 0; i < NW; i++) begin
      if (op && sel_x[i]) mem[i] = in_bus;
    end
  end

  always @(sel_x or op or in_bus or mem[0] or mem[1] or mem[2] or mem[3]) begin
    out_bus = '0;
    for (int i = 0; i < NW; i++) begin
      if (sel_x[i]) out_bus = mem[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    req_we[id]               = we;
    req_addr[id*AW +: AW]    = addr;
    req_wdata[id*DW +: DW]   = wd;
    req_valid[id]            = 1'b1;
  endtask

  // One complete transaction for requester id, checked against the model.
  task automatic do_tx(input bit id, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input bit hold_other, input string tag);
    int            waitc;
    int            lat;
    int            exp_lat;
    int            op_cycles;
    int            sel_cycles;
    int            sel_bad;
    int            ready_bad;
    int            inbus_bad;
    bit            err;
    logic [NW-1:0] exp_sel;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] held_rd;

    err     = (addr >= AW'(NW));
    exp_sel = err ? '0 : (NW'(1) << addr);
    exp_lat = err ? 1 : (we ? 2 + WRP : 1 + RDW);
    exp_rd  = (err || we) ? '0 : exp_mem[addr];

    set_req(id, we, addr, wd);
    waitc = 0;
    while (!req_ready[id] && waitc < 20) begin
      tick();
      waitc++;
    end
    check({tag, " grant"}, {30'd0, req_ready}, id ? 32'd2 : 32'd1);
    tick();
    req_valid[id] = 1'b0;
    model_last = id;
    if (hold_other) set_req(!id, 1'b0, addr, 8'h00);

    lat = 1; op_cycles = 0; sel_cycles = 0; sel_bad = 0; ready_bad = 0; inbus_bad = 0;
    while (!rsp_valid && lat < 40) begin
      if (op) op_cycles++;
      if (sel_x != '0) begin
        sel_cycles++;
        if (sel_x != exp_sel) sel_bad++;
      end
      if (req_ready != 2'b00) ready_bad++;
      if (we && !err && in_bus != wd) inbus_bad++;
      tick();
      lat++;
    end
    // Response cycle: array idle, data still on in_bus for writes.
    if (op || sel_x != '0) sel_bad++;
    if (req_ready != 2'b00) ready_bad++;
    if (we && !err && in_bus != wd) inbus_bad++;

    check({tag, " latency"},   lat, exp_lat);
    check({tag, " rsp_id"},    {31'd0, rsp_id}, {31'd0, id});
    check({tag, " rsp_err"},   {31'd0, rsp_err}, {31'd0, err});
    check({tag, " rsp_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_rd});
    check({tag, " op_cycles"}, op_cycles, (we && !err) ? WRP : 0);
    check({tag, " sel_cycles"}, sel_cycles, err ? 0 : (we ? WRP : RDW));
    check({tag, " sel_ok"},    sel_bad, 0);
    check({tag, " ready_busy"}, ready_bad, 0);
    check({tag, " in_bus"},    inbus_bad, 0);
    if (we && !err) exp_mem[addr] = wd;

    held_rd = rsp_rdata;
    tick();
    check({tag, " rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " rsp_hold"},  {24'd0, rsp_rdata}, {24'd0, held_rd});
    if (hold_other) check({tag, " next_grant"}, {30'd0, req_ready}, id ? 32'd1 : 32'd2);
  endtask

  initial begin
    int cyc;
    int gidx;
    bit gid;

    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NW; i++) begin
      mem[i]     = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    model_last = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst sel_x",     {28'd0, sel_x}, 32'd0);
    check("rst op",        {31'd0, op}, 32'd0);
    check("rst in_bus",    {24'd0, in_bus}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_id",    {31'd0, rsp_id}, 32'd0);
    check("rst rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle ready", {30'd0, req_ready}, 32'd0);

    // 1: write then read back on requester 0
    do_tx(1'b0, 1'b1, 4'd2, 8'h55, 1'b0, "t1 wr");
    do_tx(1'b0, 1'b0, 4'd2, 8'h00, 1'b0, "t1 rd");

    // 4: out-of-range read from requester 1
    do_tx(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, "t4 err");

    // 3: untouched word stays untouched
    do_tx(1'b0, 1'b1, 4'd3, 8'hFF, 1'b0, "t3 wr");
    do_tx(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, "t3 rd0");
    do_tx(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, "t3 rd3");

    // 2: both requesters valid every cycle, grants alternate
    set_req(1'b0, 1'b1, 4'd0, 8'hCC);
    set_req(1'b1, 1'b1, 4'd1, 8'h33);
    gidx = 0;
    cyc  = 0;
    while (gidx < 4 && cyc < 100) begin
      if (req_ready != 2'b00) begin
        gid = !model_last;
        check("t2 alternate", {30'd0, req_ready}, gid ? 32'd2 : 32'd1);
        model_last = gid;
        gidx++;
      end
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    check("t2 grant count", gidx, 4);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t2 final rsp", {31'd0, rsp_valid}, 32'd1);
    tick();
    exp_mem[0] = 8'hCC;
    exp_mem[1] = 8'h33;
    do_tx(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, "t2 rd0");
    do_tx(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, "t2 rd1");

    // 6: other requester waits while a transaction is in flight
    do_tx(1'b0, 1'b1, 4'd2, 8'h3C, 1'b1, "t6 wr");
    do_tx(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, "t6 rd");

    // 5: reset in the second strobe cycle
    set_req(1'b0, 1'b1, 4'd1, 8'hA5);
    cyc = 0;
    while (!req_ready[0] && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    req_valid = 2'b00;
    tick();
    check("t5 strobe1 op", {31'd0, op}, 32'd1);
    tick();
    check("t5 strobe2 op", {31'd0, op}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async op",    {31'd0, op}, 32'd0);
    check("t5 async sel_x", {28'd0, sel_x}, 32'd0);
    tick();
    rst_n = 1'b1;
    model_last = 1'b1;
    set_req(1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1'b1, 1'b0, 4'd0, 8'h00);
    #1;
    check("t5 ready after rst", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();
    do_tx(1'b0, 1'b1, 4'd1, 8'h5A, 1'b0, "t5 rewrite");
    do_tx(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, "t5 rd");

    // Randomised traffic against the model
    for (int k = 0; k < 24; k++) begin
      do_tx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 5)), 8'($urandom), 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_wordcell_array_ctrl
`default_nettype wire
